// File: rtl/hazard_scoreboard_pkg.sv
// Shared types for the issue-stage hazard scoreboard.
//
//   rv32i_type   : architectural register index and data word types.
//   hazard_types : scoreboard configuration defaults and counter type.
//
// No ports; compile these packages before the interface and modules.

package rv32i_type;

    typedef logic [4:0]  rv32i_reg;
    typedef logic [31:0] rv32i_word;

endpackage : rv32i_type

package hazard_types;

    // Default width of one per-register in-flight write counter.
    localparam int unsigned CNT_W_DEFAULT = 2;

    // x0..x31; x0 has no counter.
    localparam int unsigned NUM_REGS = 32;

    // Counter type at the default width.
    typedef logic [CNT_W_DEFAULT-1:0] sb_cnt_t;

endpackage : hazard_types

// File: rtl/hazard_scoreboard_if.sv
// Decode/execute handshake and writeback bus seen by hazard_scoreboard.
//
// Signals (named from the scoreboard's point of view):
//   valid_i, ready_i        decode holds an instruction / execute can accept
//   rs1_i, rs2_i, rd_i      source and destination register indices
//   use_rs1_i, use_rs2_i    instruction reads rs1 / rs2
//   rd_we_i                 instruction writes rd
//   wb_valid_i, wb_rd_i     regfile write completing this cycle
//   flush_i                 discard all in-flight tracking
//   valid_o, ready_o        issue to execute / decode may advance
//   hazard_o                current instruction blocked by the scoreboard
//   busy_o, err_o           any write in flight / sticky underflow flag
//   stall_cnt_o             count of cycles stalled by a hazard
//
// Modports: master = pipeline side driving the *_i signals,
//           slave  = the scoreboard.

interface hazard_scoreboard_if;

    import rv32i_type::*;

    logic      valid_i;
    logic      ready_i;
    rv32i_reg  rs1_i;
    rv32i_reg  rs2_i;
    rv32i_reg  rd_i;
    logic      use_rs1_i;
    logic      use_rs2_i;
    logic      rd_we_i;
    logic      wb_valid_i;
    rv32i_reg  wb_rd_i;
    logic      flush_i;

    logic      valid_o;
    logic      ready_o;
    logic      hazard_o;
    logic      busy_o;
    logic      err_o;
    rv32i_word stall_cnt_o;

    modport master (
        output valid_i, ready_i, rs1_i, rs2_i, rd_i,
               use_rs1_i, use_rs2_i, rd_we_i,
               wb_valid_i, wb_rd_i, flush_i,
        input  valid_o, ready_o, hazard_o, busy_o, err_o, stall_cnt_o
    );

    modport slave (
        input  valid_i, ready_i, rs1_i, rs2_i, rd_i,
               use_rs1_i, use_rs2_i, rd_we_i,
               wb_valid_i, wb_rd_i, flush_i,
        output valid_o, ready_o, hazard_o, busy_o, err_o, stall_cnt_o
    );

endinterface : hazard_scoreboard_if

// File: rtl/hazard_scoreboard_cnt.sv
// scoreboard_cnt: one saturating up/down counter tracking the writes in
// flight to a single architectural register.
//
// Ports:
//   clk    rising-edge clock
//   rst    asynchronous active-high reset, clears the count
//   clr_i  synchronous clear, wins over inc_i/dec_i
//   inc_i  a write to this register was issued
//   dec_i  a write to this register completed
//   cnt_o  current count (registered)
//
// inc_i and dec_i together leave the count unchanged. The count neither
// wraps above all-ones nor below zero.

module scoreboard_cnt
    import hazard_types::*;
#(
    parameter int unsigned CNT_W = CNT_W_DEFAULT
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr_i,
    input  logic             inc_i,
    input  logic             dec_i,
    output logic [CNT_W-1:0] cnt_o
);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (inc_i && !dec_i && (cnt_q != '1)) begin
            cnt_d = cnt_q + CNT_W'(1);
        end else if (dec_i && !inc_i && (cnt_q != '0)) begin
            cnt_d = cnt_q - CNT_W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt_o = cnt_q;

endmodule : scoreboard_cnt

// File: rtl/hazard_scoreboard.sv
// hazard_scoreboard: issue-stage register scoreboard for an RV32I pipeline.
// Tracks in-flight writes per register (x1..x31) and blocks issue of an
// instruction that reads a pending register or would overflow the counter
// of its destination.
//
// Ports:
//   clk   rising-edge clock
//   rst   asynchronous active-high reset (drops all tracking)
//   bus   hazard_scoreboard_if.slave -- decode handshake, writeback,
//         flush, status and stall counter (see the interface file)
//
// Parameters:
//   CNT_W  width of each per-register counter; at most 2^CNT_W-1 writes
//          may be in flight to one register.
//
// Build option:
//   WB_BYPASS_EN  when defined, a source whose only pending write is
//                 completing this cycle is not a hazard (the regfile writes
//                 through). When undefined, any pending write is a hazard.

module hazard_scoreboard
    import rv32i_type::*;
    import hazard_types::*;
#(
    parameter int unsigned CNT_W = CNT_W_DEFAULT
) (
    input  logic                clk,
    input  logic                rst,
    hazard_scoreboard_if.slave  bus
);

    // Entry 0 is tied to zero so x0 lookups never see a pending write.
    logic [NUM_REGS-1:0][CNT_W-1:0] cnt_vec;

    logic [NUM_REGS-1:1] inc_vec;
    logic [NUM_REGS-1:1] dec_vec;

    logic [CNT_W-1:0] rs1_cnt;
    logic [CNT_W-1:0] rs2_cnt;
    logic [CNT_W-1:0] rd_cnt;
    logic [CNT_W-1:0] wb_cnt;

    logic rs1_busy;
    logic rs2_busy;
    logic rd_full;
    logic hazard;
    logic issue;
    logic issue_wr;
    logic wb_hit;
    logic underflow;
    logic stall;

    logic      err_q;
    logic      err_d;
    rv32i_word stall_cnt_q;
    rv32i_word stall_cnt_d;

    // ------------------------------------------------------------------
    // Hazard detection (purely combinational from inputs and counters)
    // ------------------------------------------------------------------
    always_comb begin
        rs1_cnt = cnt_vec[bus.rs1_i];
        rs2_cnt = cnt_vec[bus.rs2_i];
        rd_cnt  = cnt_vec[bus.rd_i];

        rs1_busy = bus.use_rs1_i && (rs1_cnt != '0);
        rs2_busy = bus.use_rs2_i && (rs2_cnt != '0);
`ifdef WB_BYPASS_EN
        // Last pending write retiring this cycle: the read sees the new
        // value through the regfile, so the source is already safe.
        if (bus.wb_valid_i && (bus.wb_rd_i == bus.rs1_i) && (rs1_cnt == CNT_W'(1))) begin
            rs1_busy = 1'b0;
        end
        if (bus.wb_valid_i && (bus.wb_rd_i == bus.rs2_i) && (rs2_cnt == CNT_W'(1))) begin
            rs2_busy = 1'b0;
        end
`endif
        rd_full = bus.rd_we_i && (bus.rd_i != '0) && (rd_cnt == '1);

        hazard = bus.valid_i && (rs1_busy || rs2_busy || rd_full);
    end

    assign issue    = bus.valid_i && bus.ready_i && !hazard && !bus.flush_i;
    assign issue_wr = issue && bus.rd_we_i && (bus.rd_i != '0);
    assign stall    = bus.valid_i && bus.ready_i && hazard;

    // ------------------------------------------------------------------
    // Writeback bookkeeping
    // ------------------------------------------------------------------
    assign wb_cnt    = cnt_vec[bus.wb_rd_i];
    assign wb_hit    = bus.wb_valid_i && (bus.wb_rd_i != '0);
    assign underflow = wb_hit && (wb_cnt == '0);

    // Decrements are only requested for a non-zero count, so a same-cycle
    // issue to an idle register still counts up while err is raised.
    always_comb begin
        inc_vec = '0;
        dec_vec = '0;
        for (int unsigned i = 1; i < NUM_REGS; i++) begin
            inc_vec[i] = issue_wr && (bus.rd_i == rv32i_reg'(i));
            dec_vec[i] = wb_hit && (wb_cnt != '0) && (bus.wb_rd_i == rv32i_reg'(i));
        end
    end

    assign cnt_vec[0] = '0;

    for (genvar g = 1; g < NUM_REGS; g++) begin : g_cnt
        scoreboard_cnt #(
            .CNT_W (CNT_W)
        ) u_cnt (
            .clk   (clk),
            .rst   (rst),
            .clr_i (bus.flush_i),
            .inc_i (inc_vec[g]),
            .dec_i (dec_vec[g]),
            .cnt_o (cnt_vec[g])
        );
    end

    // ------------------------------------------------------------------
    // Sticky error and stall counter
    // ------------------------------------------------------------------
    always_comb begin
        err_d       = err_q || underflow;
        stall_cnt_d = stall_cnt_q;
        if (stall) begin
            stall_cnt_d = stall_cnt_q + 32'd1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err_q       <= 1'b0;
            stall_cnt_q <= '0;
        end else begin
            err_q       <= err_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign bus.hazard_o    = hazard;
    assign bus.valid_o     = issue;
    assign bus.ready_o     = bus.ready_i && !hazard;
    assign bus.busy_o      = |cnt_vec;
    assign bus.err_o       = err_q;
    assign bus.stall_cnt_o = stall_cnt_q;

endmodule : hazard_scoreboard

// File: tb/tb_hazard_scoreboard.sv
// Self-checking bench for hazard_scoreboard: directed scenarios followed by
// randomized traffic, all checked against a behavioural register-count model.

module tb_hazard_scoreboard;

    localparam int unsigned CNT_W = 2;
    localparam int          CMAX  = (1 << CNT_W) - 1;

    logic clk = 1'b0;
    logic rst = 1'b1;

    int errors = 0;
    int checks = 0;

    int          model_cnt [32];
    bit          model_err;
    logic [31:0] model_stall;

    hazard_scoreboard_if bus ();

    hazard_scoreboard #(
        .CNT_W (CNT_W)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    // ------------------------------------------------------------------
    // Reference model
    // ------------------------------------------------------------------
    function automatic void model_reset();
        foreach (model_cnt[i]) model_cnt[i] = 0;
        model_err   = 1'b0;
        model_stall = '0;
    endfunction

    function automatic bit src_pending(logic [4:0] r);
        if (r == 0 || model_cnt[r] == 0) return 1'b0;
`ifdef WB_BYPASS_EN
        if (bus.wb_valid_i && bus.wb_rd_i == r && model_cnt[r] == 1) return 1'b0;
`endif
        return 1'b1;
    endfunction

    function automatic bit exp_hazard();
        if (!bus.valid_i) return 1'b0;
        if (bus.use_rs1_i && src_pending(bus.rs1_i)) return 1'b1;
        if (bus.use_rs2_i && src_pending(bus.rs2_i)) return 1'b1;
        if (bus.rd_we_i && bus.rd_i != 0 && model_cnt[bus.rd_i] == CMAX) return 1'b1;
        return 1'b0;
    endfunction

    function automatic bit exp_issue();
        return bus.valid_i && bus.ready_i && !exp_hazard() && !bus.flush_i;
    endfunction

    function automatic bit exp_busy();
        foreach (model_cnt[i]) if (model_cnt[i] != 0) return 1'b1;
        return 1'b0;
    endfunction

    // Applies the effect of one clock edge given the inputs now on the bus.
    function automatic void model_advance();
        bit haz, inc, dec;
        haz = exp_hazard();
        inc = exp_issue() && bus.rd_we_i && bus.rd_i != 0;
        dec = bus.wb_valid_i && bus.wb_rd_i != 0 && model_cnt[bus.wb_rd_i] > 0;
        if (bus.valid_i && bus.ready_i && haz) model_stall = model_stall + 1;
        if (bus.wb_valid_i && bus.wb_rd_i != 0 && model_cnt[bus.wb_rd_i] == 0) model_err = 1'b1;
        if (bus.flush_i) begin
            foreach (model_cnt[i]) model_cnt[i] = 0;
        end else if (!(inc && dec && bus.rd_i == bus.wb_rd_i)) begin
            if (inc && model_cnt[bus.rd_i] < CMAX) model_cnt[bus.rd_i]++;
            if (dec) model_cnt[bus.wb_rd_i]--;
        end
    endfunction

    // ------------------------------------------------------------------
    // Stimulus helpers (no checking)
    // ------------------------------------------------------------------
    task automatic clear_inputs();
        bus.valid_i    = 1'b0;
        bus.ready_i    = 1'b0;
        bus.rs1_i      = '0;
        bus.rs2_i      = '0;
        bus.rd_i       = '0;
        bus.use_rs1_i  = 1'b0;
        bus.use_rs2_i  = 1'b0;
        bus.rd_we_i    = 1'b0;
        bus.wb_valid_i = 1'b0;
        bus.wb_rd_i    = '0;
        bus.flush_i    = 1'b0;
    endtask

    task automatic tick();
        model_advance();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        clear_inputs();
        rst = 1'b1;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        #1;
    endtask

    task automatic issue_write(input logic [4:0] rd);
        clear_inputs();
        bus.valid_i = 1'b1;
        bus.ready_i = 1'b1;
        bus.rd_we_i = 1'b1;
        bus.rd_i    = rd;
        tick();
    endtask

    task automatic writeback(input logic [4:0] rd);
        clear_inputs();
        bus.wb_valid_i = 1'b1;
        bus.wb_rd_i    = rd;
        tick();
    endtask

    // ------------------------------------------------------------------
    // Scenarios
    // ------------------------------------------------------------------
    task automatic test_reset();
        clear_inputs();
        rst = 1'b1;
        model_reset();
        #3;
        checks++; if (bus.stall_cnt_o !== 32'd0) begin errors++; $display("FAIL reset_stall: got %0d want 0", bus.stall_cnt_o); end
        checks++; if (bus.busy_o !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", bus.busy_o); end
        checks++; if (bus.err_o !== 1'b0) begin errors++; $display("FAIL reset_err: got %b want 0", bus.err_o); end
        checks++; if (bus.valid_o !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b want 0", bus.valid_o); end
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        #1;
        checks++; if (bus.hazard_o !== 1'b0) begin errors++; $display("FAIL reset_hazard: got %b want 0", bus.hazard_o); end
    endtask

    task automatic test_raw_hazard();
        clear_inputs();
        bus.valid_i = 1'b1; bus.ready_i = 1'b1; bus.rd_we_i = 1'b1; bus.rd_i = 5'd5;
        #1;
        checks++; if (bus.valid_o !== 1'b1) begin errors++; $display("FAIL raw_issue_wr: valid_o=%b want 1", bus.valid_o); end
        tick();
        clear_inputs();
        bus.valid_i = 1'b1; bus.ready_i = 1'b1; bus.use_rs1_i = 1'b1; bus.rs1_i = 5'd5;
        #1;
        checks++; if (bus.hazard_o !== 1'b1) begin errors++; $display("FAIL raw_hazard: hazard_o=%b want 1", bus.hazard_o); end
        checks++; if (bus.valid_o !== 1'b0) begin errors++; $display("FAIL raw_blocked: valid_o=%b want 0", bus.valid_o); end
        checks++; if (bus.ready_o !== 1'b0) begin errors++; $display("FAIL raw_ready: ready_o=%b want 0", bus.ready_o); end
        tick();
        #1;
        checks++; if (bus.hazard_o !== 1'b1) begin errors++; $display("FAIL raw_hazard_hold: hazard_o=%b want 1", bus.hazard_o); end
        tick();
        bus.wb_valid_i = 1'b1; bus.wb_rd_i = 5'd5;
        #1;
`ifdef WB_BYPASS_EN
        checks++; if (bus.hazard_o !== 1'b0) begin errors++; $display("FAIL raw_wb_cycle: hazard_o=%b want 0", bus.hazard_o); end
`else
        checks++; if (bus.hazard_o !== 1'b1) begin errors++; $display("FAIL raw_wb_cycle: hazard_o=%b want 1", bus.hazard_o); end
`endif
        tick();
        bus.wb_valid_i = 1'b0;
        #1;
        checks++; if (bus.valid_o !== 1'b1) begin errors++; $display("FAIL raw_release: valid_o=%b want 1", bus.valid_o); end
        checks++; if (bus.busy_o !== 1'b0) begin errors++; $display("FAIL raw_idle: busy_o=%b want 0", bus.busy_o); end
        tick();
        clear_inputs();
    endtask

    task automatic test_x0();
        for (int i = 0; i < 6; i++) begin
            clear_inputs();
            bus.valid_i = 1'b1; bus.ready_i = 1'b1;
            bus.rd_we_i = 1'b1; bus.rd_i = 5'd0;
            bus.use_rs1_i = 1'b1; bus.rs1_i = 5'd0;
            bus.use_rs2_i = (i % 2 == 1); bus.rs2_i = 5'd0;
            #1;
            checks++; if (bus.hazard_o !== 1'b0) begin errors++; $display("FAIL x0_hazard[%0d]: got %b want 0", i, bus.hazard_o); end
            checks++; if (bus.busy_o !== 1'b0) begin errors++; $display("FAIL x0_busy[%0d]: got %b want 0", i, bus.busy_o); end
            checks++; if (bus.valid_o !== 1'b1) begin errors++; $display("FAIL x0_valid[%0d]: got %b want 1", i, bus.valid_o); end
            tick();
        end
        clear_inputs();
    endtask

    task automatic test_saturation();
        for (int i = 0; i < 3; i++) begin
            clear_inputs();
            bus.valid_i = 1'b1; bus.ready_i = 1'b1; bus.rd_we_i = 1'b1; bus.rd_i = 5'd7;
            #1;
            checks++; if (bus.valid_o !== 1'b1) begin errors++; $display("FAIL sat_issue[%0d]: valid_o=%b want 1", i, bus.valid_o); end
            tick();
        end
        #1;
        checks++; if (bus.hazard_o !== 1'b1) begin errors++; $display("FAIL sat_fourth: hazard_o=%b want 1", bus.hazard_o); end
        checks++; if (bus.valid_o !== 1'b0) begin errors++; $display("FAIL sat_fourth_valid: valid_o=%b want 0", bus.valid_o); end
        tick();
        bus.wb_valid_i = 1'b1; bus.wb_rd_i = 5'd7;
        #1;
        checks++; if (bus.hazard_o !== 1'b1) begin errors++; $display("FAIL sat_wb_cycle: hazard_o=%b want 1", bus.hazard_o); end
        tick();
        bus.wb_valid_i = 1'b0;
        #1;
        checks++; if (bus.valid_o !== 1'b1) begin errors++; $display("FAIL sat_release: valid_o=%b want 1", bus.valid_o); end
        tick();
        for (int i = 0; i < 3; i++) writeback(5'd7);
        #1;
        checks++; if (bus.busy_o !== 1'b0 || bus.err_o !== 1'b0) begin errors++; $display("FAIL sat_drain: busy_o=%b err_o=%b want 0 0", bus.busy_o, bus.err_o); end
    endtask

    task automatic test_same_cycle();
        issue_write(5'd9);
        clear_inputs();
        bus.valid_i = 1'b1; bus.ready_i = 1'b1; bus.rd_we_i = 1'b1; bus.rd_i = 5'd9;
        bus.wb_valid_i = 1'b1; bus.wb_rd_i = 5'd9;
        #1;
        checks++; if (bus.valid_o !== 1'b1) begin errors++; $display("FAIL same_issue: valid_o=%b want 1", bus.valid_o); end
        tick();
        clear_inputs();
        bus.valid_i = 1'b1; bus.ready_i = 1'b1; bus.use_rs2_i = 1'b1; bus.rs2_i = 5'd9;
        #1;
        checks++; if (bus.hazard_o !== 1'b1) begin errors++; $display("FAIL same_pending: hazard_o=%b want 1", bus.hazard_o); end
        bus.wb_valid_i = 1'b1; bus.wb_rd_i = 5'd9;
        #1;
`ifdef WB_BYPASS_EN
        checks++; if (bus.hazard_o !== 1'b0) begin errors++; $display("FAIL same_bypass: hazard_o=%b want 0", bus.hazard_o); end
`else
        checks++; if (bus.hazard_o !== 1'b1) begin errors++; $display("FAIL same_bypass: hazard_o=%b want 1", bus.hazard_o); end
`endif
        tick();
        clear_inputs();
        #1;
        // A single writeback empties x9 only if the paired issue+wb held it at 1.
        checks++; if (bus.busy_o !== 1'b0) begin errors++; $display("FAIL same_count1: busy_o=%b want 0", bus.busy_o); end
    endtask

    task automatic test_underflow_flush();
        clear_inputs();
        bus.wb_valid_i = 1'b1; bus.wb_rd_i = 5'd3;
        #1;
        checks++; if (bus.err_o !== 1'b0) begin errors++; $display("FAIL uf_before: err_o=%b want 0", bus.err_o); end
        tick();
        clear_inputs();
        #1;
        checks++; if (bus.err_o !== 1'b1) begin errors++; $display("FAIL uf_set: err_o=%b want 1", bus.err_o); end
        checks++; if (bus.busy_o !== 1'b0) begin errors++; $display("FAIL uf_count: busy_o=%b want 0", bus.busy_o); end
        tick();
        tick();
        checks++; if (bus.err_o !== 1'b1) begin errors++; $display("FAIL uf_sticky: err_o=%b want 1", bus.err_o); end
        issue_write(5'd1);
        issue_write(5'd2);
        issue_write(5'd4);
        issue_write(5'd6);
        clear_inputs();
        #1;
        checks++; if (bus.busy_o !== 1'b1) begin errors++; $display("FAIL fl_pending: busy_o=%b want 1", bus.busy_o); end
        bus.flush_i = 1'b1;
        bus.valid_i = 1'b1; bus.ready_i = 1'b1; bus.rd_we_i = 1'b1; bus.rd_i = 5'd10;
        bus.wb_valid_i = 1'b1; bus.wb_rd_i = 5'd1;
        #1;
        checks++; if (bus.valid_o !== 1'b0) begin errors++; $display("FAIL fl_valid: valid_o=%b want 0", bus.valid_o); end
        tick();
        clear_inputs();
        bus.valid_i = 1'b1; bus.ready_i = 1'b1; bus.use_rs1_i = 1'b1; bus.rs1_i = 5'd2;
        #1;
        checks++; if (bus.busy_o !== 1'b0) begin errors++; $display("FAIL fl_busy: busy_o=%b want 0", bus.busy_o); end
        checks++; if (bus.hazard_o !== 1'b0) begin errors++; $display("FAIL fl_hazard: hazard_o=%b want 0", bus.hazard_o); end
        checks++; if (bus.err_o !== 1'b1) begin errors++; $display("FAIL fl_err_kept: err_o=%b want 1", bus.err_o); end
        tick();
        clear_inputs();
    endtask

    task automatic test_stall_async_rst();
        do_reset();
        writeback(5'd3);
        issue_write(5'd12);
        clear_inputs();
        bus.valid_i = 1'b1; bus.ready_i = 1'b1; bus.use_rs1_i = 1'b1; bus.rs1_i = 5'd12;
        repeat (10) tick();
        #1;
        checks++; if (bus.stall_cnt_o !== 32'd10) begin errors++; $display("FAIL stall_count: got %0d want 10", bus.stall_cnt_o); end
        checks++; if (bus.err_o !== 1'b1 || bus.busy_o !== 1'b1) begin errors++; $display("FAIL stall_state: err_o=%b busy_o=%b want 1 1", bus.err_o, bus.busy_o); end
        #2;
        rst = 1'b1;
        #1;
        checks++; if (bus.stall_cnt_o !== 32'd0) begin errors++; $display("FAIL arst_stall: got %0d want 0", bus.stall_cnt_o); end
        checks++; if (bus.err_o !== 1'b0) begin errors++; $display("FAIL arst_err: got %b want 0", bus.err_o); end
        checks++; if (bus.busy_o !== 1'b0) begin errors++; $display("FAIL arst_busy: got %b want 0", bus.busy_o); end
        checks++; if (bus.hazard_o !== 1'b0) begin errors++; $display("FAIL arst_hazard: got %b want 0", bus.hazard_o); end
        do_reset();
    endtask

    task automatic test_random();
        logic [4:0] pend [$];
        bit         e_haz;
        for (int n = 0; n < 400; n++) begin
            clear_inputs();
            bus.valid_i   = ($urandom_range(0, 3) != 0);
            bus.ready_i   = ($urandom_range(0, 3) != 0);
            bus.rs1_i     = 5'($urandom_range(0, 7));
            bus.rs2_i     = 5'($urandom_range(0, 7));
            bus.rd_i      = 5'($urandom_range(0, 7));
            bus.use_rs1_i = $urandom_range(0, 1) != 0;
            bus.use_rs2_i = $urandom_range(0, 1) != 0;
            bus.rd_we_i   = $urandom_range(0, 3) != 0;
            bus.flush_i   = ($urandom_range(0, 49) == 0);
            pend.delete();
            for (int r = 1; r < 32; r++) if (model_cnt[r] != 0) pend.push_back(5'(r));
            if (pend.size() != 0 && $urandom_range(0, 2) == 0) begin
                bus.wb_valid_i = 1'b1;
                bus.wb_rd_i    = pend[$urandom_range(0, pend.size() - 1)];
            end
            #1;
            e_haz = exp_hazard();
            checks++; if (bus.hazard_o !== e_haz) begin errors++; $display("FAIL rnd_hazard[%0d]: got %b want %b", n, bus.hazard_o, e_haz); end
            checks++; if (bus.valid_o !== exp_issue()) begin errors++; $display("FAIL rnd_valid[%0d]: got %b want %b", n, bus.valid_o, exp_issue()); end
            checks++; if (bus.ready_o !== (bus.ready_i && !e_haz)) begin errors++; $display("FAIL rnd_ready[%0d]: got %b want %b", n, bus.ready_o, bus.ready_i && !e_haz); end
            checks++; if (bus.busy_o !== exp_busy()) begin errors++; $display("FAIL rnd_busy[%0d]: got %b want %b", n, bus.busy_o, exp_busy()); end
            checks++; if (bus.err_o !== model_err) begin errors++; $display("FAIL rnd_err[%0d]: got %b want %b", n, bus.err_o, model_err); end
            checks++; if (bus.stall_cnt_o !== model_stall) begin errors++; $display("FAIL rnd_stall[%0d]: got %0d want %0d", n, bus.stall_cnt_o, model_stall); end
            tick();
        end
        clear_inputs();
    endtask

    initial begin
        test_reset();
        test_raw_hazard();
        test_x0();
        test_saturation();
        test_same_cycle();
        test_underflow_flush();
        test_stall_async_rst();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule : tb_hazard_scoreboard

// File: doc/hazard_scoreboard.md
HAZARD_SCOREBOARD -- requirements
Module: hazard_scoreboard

Interface
REQ-001 SHALL have parameter CNT_W, default 2, width of the per-register in-flight write counter (max in-flight writes per register = 2^CNT_W - 1).
REQ-002 SHALL have port clk  input  1  rising-edge clock.
REQ-003 SHALL have port rst  input  1  reset, asynchronous and active-high.
REQ-004 SHALL have port valid_i  input  1  decode holds an instruction.
REQ-005 SHALL have port ready_i  input  1  downstream (execute) can accept.
REQ-006 SHALL have ports rs1_i, rs2_i, rd_i  input  5 each  source/dest register indices (rv32i_reg).
REQ-007 SHALL have port use_rs1_i, use_rs2_i, rd_we_i  input  1 each  instruction reads rs1 / reads rs2 / writes rd.
REQ-008 SHALL have port wb_valid_i  input  1; wb_rd_i  input  5  regfile write completing this cycle.
REQ-009 SHALL have port flush_i  input  1  discard all in-flight tracking.
REQ-010 SHALL have ports valid_o  output  1  issue to execute; ready_o  output  1  decode may advance.
REQ-011 SHALL have port hazard_o  output  1  current instruction blocked by scoreboard.
REQ-012 SHALL have port busy_o  output  1  any counter non-zero; err_o  output  1  sticky underflow flag.
REQ-013 SHALL have port stall_cnt_o  output  32  cycles with valid_i & ready_i & hazard_o.

Function
REQ-014 SHALL keep one CNT_W-bit counter per register x1..x31; x0 SHALL never be tracked and never cause a hazard.
REQ-015 SHALL assert hazard_o combinationally when valid_i and (use_rs1_i & cnt[rs1_i]!=0, or use_rs2_i & cnt[rs2_i]!=0, or rd_we_i & rd_i!=0 & cnt[rd_i] saturated).
REQ-016 SHALL drive valid_o = valid_i & ready_i & ~hazard_o & ~flush_i and ready_o = ready_i & ~hazard_o; zero latency, no registers on these paths.
REQ-017 SHALL increment cnt[rd_i] on the clock edge where valid_o & rd_we_i & rd_i!=0.
REQ-018 SHALL decrement cnt[wb_rd_i] on the edge where wb_valid_i & wb_rd_i!=0 & count non-zero.
REQ-019 SHALL leave the counter unchanged when increment and decrement hit the same register in the same cycle.
REQ-020 SHALL, on wb_valid_i to a register with count 0 (x1..x31), leave count at 0 and set err_o until reset.
REQ-021 SHALL, on flush_i, clear all counters at the next edge; flush takes priority over same-cycle increment and decrement.
REQ-022 SHALL increment stall_cnt_o by 1 per qualifying cycle, wrapping 0xFFFFFFFF -> 0.
REQ-023 SHALL drive busy_o as the OR of all counters != 0 (registered state, no input dependence).

Reset
REQ-024 SHALL, while rst is high, asynchronously force all counters, err_o and stall_cnt_o to 0; busy_o=0 consequently.
REQ-025 SHALL discard tracking of writes in flight when reset is asserted mid-operation; no recovery of prior state.

Configuration
REQ-026 SHALL, with WB_BYPASS_EN defined, exclude a source from the hazard check when wb_valid_i & wb_rd_i equals that source & its count is 1 (same-cycle regfile write-through).
REQ-027 SHALL, without WB_BYPASS_EN, treat any non-zero count as a hazard regardless of same-cycle writeback.

Structure
REQ-028 SHALL take rv32i_reg and rv32i_word from rv32i_type; CNT_W default and the scoreboard counter typedef SHALL live in a new shared package hazard_types.
REQ-029 SHALL use one sub-module, scoreboard_cnt, implementing a single saturating up/down counter with async reset and clear, instantiated 31 times.

Verification
REQ-030 SHALL cover: issue rd=x5 write, next cycle rs1=x5 -> hazard_o=1, valid_o=0 until wb_rd=x5, then valid_o=1 next cycle.
REQ-031 SHALL cover: rd=x0 writes and rs1=x0 reads back-to-back -> hazard_o never 1, busy_o stays 0.
REQ-032 SHALL cover: three issues to x7 (CNT_W=2) -> fourth write to x7 blocked; one wb to x7 -> fourth issues.
REQ-033 SHALL cover: same-cycle issue to x9 and wb to x9 with count 1 -> count stays 1; with WB_BYPASS_EN, rs2=x9 with count 1 and wb x9 -> no hazard.
REQ-034 SHALL cover: wb to x3 with count 0 -> err_o=1 and held; flush_i with 4 registers pending -> busy_o=0 next cycle.
REQ-035 SHALL cover: stall_cnt_o preloaded via 10 stall cycles = 10; async rst mid-stall -> all outputs 0 without clock edge.
